// File: rtl/argmax_stream.sv
// Streaming argmax: scans N elements (one per accepted beat) and reports the
// first index of the maximum. Optional ARGMAX_STREAM_TOP2_EN adds runner-up outputs.
module argmax_stream #(
  parameter int N      = 10,
  parameter int W      = 16,
  parameter int IDX_W  = 4,
  parameter int SIGNED = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  output logic             in_ready,
  output logic [IDX_W-1:0] max_index,
  output logic [W-1:0]     max_value,
  output logic             busy,
  output logic             done
`ifdef ARGMAX_STREAM_TOP2_EN
  ,
  output logic [IDX_W-1:0] second_index,
  output logic [W-1:0]     second_value
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] cnt;
  logic [W-1:0]     best_val, nb_val;
  logic [IDX_W-1:0] best_idx, nb_idx;
  logic             beat, first, last;

  function automatic logic gt(input logic [W-1:0] a, input logic [W-1:0] b);
    if (SIGNED != 0) return $signed(a) > $signed(b);
    else             return a > b;
  endfunction

  assign in_ready = (state == ACCUM);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  // clear outranks any beat presented in the same cycle
  assign beat     = in_valid && in_ready && !clear;
  assign first    = (cnt == '0);
  assign last     = (cnt == IDX_W'(N-1));

  always_comb begin
    nb_val = best_val;
    nb_idx = best_idx;
    if (first || gt(in_data, best_val)) begin
      nb_val = in_data;
      nb_idx = cnt;
    end
  end

`ifdef ARGMAX_STREAM_TOP2_EN
  logic [W-1:0]     sec_val, ns_val;
  logic [IDX_W-1:0] sec_idx, ns_idx;
  logic             sec_vld, ns_vld;

  // runner-up: displaced best, or a non-winning beat that beats the current runner-up
  always_comb begin
    ns_val = sec_val;
    ns_idx = sec_idx;
    ns_vld = sec_vld;
    if (first) begin
      ns_val = '0;
      ns_idx = '0;
      ns_vld = 1'b0;
    end else if (gt(in_data, best_val)) begin
      ns_val = best_val;
      ns_idx = best_idx;
      ns_vld = 1'b1;
    end else if (!sec_vld || gt(in_data, sec_val)) begin
      ns_val = in_data;
      ns_idx = cnt;
      ns_vld = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sec_val      <= '0;
      sec_idx      <= '0;
      sec_vld      <= 1'b0;
      second_index <= '0;
      second_value <= '0;
    end else if (beat) begin
      sec_val <= ns_val;
      sec_idx <= ns_idx;
      sec_vld <= ns_vld;
      if (last) begin
        second_index <= ns_idx;
        second_value <= ns_val;
      end
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && !clear) state_nxt = ACCUM;
      ACCUM:   if (clear) state_nxt = IDLE;
               else if (beat && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      max_index <= '0;
      max_value <= '0;
    end else if (clear || (state == IDLE && start)) begin
      cnt <= '0;
    end else if (beat) begin
      best_val <= nb_val;
      best_idx <= nb_idx;
      if (last) begin
        cnt       <= '0;
        max_index <= nb_idx;
        max_value <= nb_val;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule
